// File: rtl/stopwatch_counter_pkg.sv
// Shared definitions for the stopwatch: FSM encoding, BCD digit width and the ones-digit limit.
// Also holds the run/pause transition function used by the top-level FSM.
package stopwatch_counter_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] ONES_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    function automatic state_t next_state(input state_t cur, input logic start_ev);
        state_t nxt;
        nxt = cur;
        if (start_ev) begin
            unique case (cur)
                IDLE:    nxt = RUNNING;
                RUNNING: nxt = PAUSED;
                PAUSED:  nxt = RUNNING;
                default: nxt = IDLE;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control inputs and display/status outputs of the stopwatch, grouped as one bundle.
// master = controller driving tick/start/clear, slave = the stopwatch itself.
interface stopwatch_counter_if;
    import stopwatch_counter_pkg::*;

    logic                   tick_in;
    logic                   start_stop;
    logic                   clear;
    logic [4*DIGIT_W-1:0]   digits;
    logic                   running;
    logic                   rollover;

    modport master (
        output tick_in, start_stop, clear,
        input  digits, running, rollover
    );

    modport slave (
        input  tick_in, start_stop, clear,
        output digits, running, rollover
    );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit: counts 0..max_value on inc, wraps to 0 and raises a combinational carry.
// Latency 1 cycle from inc to value; no backpressure, inc is always accepted.
module bcd_digit
    import stopwatch_counter_pkg::*;
(
    input  logic               clock_in,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc,
    input  logic [DIGIT_W-1:0] max_value,
    output logic [DIGIT_W-1:0] value,
    output logic               carry
);

    assign carry = inc && (value == max_value);

    always_ff @(posedge clock_in) begin
        if (reset || clear) begin
            value <= '0;
        end else if (inc) begin
            value <= carry ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch with run/pause FSM; digits update 1 cycle after a sampled tick edge.
// No backpressure: ticks and start_stop edges are consumed the cycle they are detected.
module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter int SEC_TENS_MAX = 5,
    parameter int MIN_TENS_MAX = 5
)
(
    input  logic                 clock_in,
    input  logic                 reset,
    stopwatch_counter_if.slave   sw
);

    localparam logic [DIGIT_W-1:0] SEC_TENS_LIM = DIGIT_W'(SEC_TENS_MAX);
    localparam logic [DIGIT_W-1:0] MIN_TENS_LIM = DIGIT_W'(MIN_TENS_MAX);

    state_t             state;
    logic               tick_prev;
    logic               ss_prev;
    logic               running_q;
    logic               rollover_q;
    logic               tick_ev;
    logic               start_ev;
    logic               inc;
    logic [DIGIT_W-1:0] sec_ones, sec_tens, min_ones, min_tens;
    logic               c_sec_ones, c_sec_tens, c_min_ones, c_min_tens;

    assign tick_ev  = sw.tick_in && !tick_prev;
    assign start_ev = sw.start_stop && !ss_prev;
    // Counting is judged on the pre-transition state, so a tick coinciding with pause still counts.
    assign inc      = tick_ev && (state == RUNNING) && !sw.clear;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            tick_prev  <= 1'b0;
            ss_prev    <= 1'b0;
            state      <= IDLE;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            // Edge history tracks through clear so a held start_stop cannot fire on clear release.
            tick_prev <= sw.tick_in;
            ss_prev   <= sw.start_stop;
            if (sw.clear) begin
                state      <= IDLE;
                running_q  <= 1'b0;
                rollover_q <= 1'b0;
            end else begin
                state      <= next_state(state, start_ev);
                running_q  <= (next_state(state, start_ev) == RUNNING);
                rollover_q <= c_min_tens;
            end
        end
    end

    bcd_digit u_sec_ones (
        .clock_in  (clock_in),
        .reset     (reset),
        .clear     (sw.clear),
        .inc       (inc),
        .max_value (ONES_MAX),
        .value     (sec_ones),
        .carry     (c_sec_ones)
    );

    bcd_digit u_sec_tens (
        .clock_in  (clock_in),
        .reset     (reset),
        .clear     (sw.clear),
        .inc       (c_sec_ones),
        .max_value (SEC_TENS_LIM),
        .value     (sec_tens),
        .carry     (c_sec_tens)
    );

    bcd_digit u_min_ones (
        .clock_in  (clock_in),
        .reset     (reset),
        .clear     (sw.clear),
        .inc       (c_sec_tens),
        .max_value (ONES_MAX),
        .value     (min_ones),
        .carry     (c_min_ones)
    );

    bcd_digit u_min_tens (
        .clock_in  (clock_in),
        .reset     (reset),
        .clear     (sw.clear),
        .inc       (c_min_ones),
        .max_value (MIN_TENS_LIM),
        .value     (min_tens),
        .carry     (c_min_tens)
    );

    assign sw.digits   = {min_tens, min_ones, sec_tens, sec_ones};
    assign sw.running  = running_q;
    assign sw.rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Stopwatch bench: elapsed-seconds reference model checked every cycle, plus directed literal checks.
module tb_stopwatch_counter;

    localparam int SEC_TENS_MAX = 5;
    localparam int MIN_TENS_MAX = 5;
    localparam int SECS_PER_MIN = (SEC_TENS_MAX + 1) * 10;
    localparam int WRAP         = SECS_PER_MIN * (MIN_TENS_MAX + 1) * 10;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic clock_in = 1'b0;
    logic reset    = 1'b1;

    stopwatch_counter_if sw();

    stopwatch_counter #(
        .SEC_TENS_MAX (SEC_TENS_MAX),
        .MIN_TENS_MAX (MIN_TENS_MAX)
    ) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .sw       (sw)
    );

    always #5 clock_in = ~clock_in;

    int checks   = 0;
    int failures = 0;

    // Reference model: elapsed seconds as a plain integer plus a run mode.
    int m_cnt  = 0;
    int m_mode = M_IDLE;
    bit m_roll = 1'b0;
    bit m_tp   = 1'b0;
    bit m_sp   = 1'b0;
    bit m_tk, m_ev;
    bit chk_on = 1'b0;

    function automatic logic [15:0] to_digits(input int c);
        int s, m;
        s = c % SECS_PER_MIN;
        m = c / SECS_PER_MIN;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock_in);
            if (reset) begin
                m_cnt  = 0;
                m_mode = M_IDLE;
                m_tp   = 1'b0;
                m_sp   = 1'b0;
                m_roll = 1'b0;
                chk_on = 1'b1;
            end else begin
                m_tk   = sw.tick_in && !m_tp;
                m_ev   = sw.start_stop && !m_sp;
                m_tp   = sw.tick_in;
                m_sp   = sw.start_stop;
                m_roll = 1'b0;
                if (sw.clear) begin
                    m_cnt  = 0;
                    m_mode = M_IDLE;
                end else begin
                    if (m_tk && m_mode == M_RUN) begin
                        m_cnt  = (m_cnt + 1) % WRAP;
                        m_roll = (m_cnt == 0);
                    end
                    if (m_ev) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
                end
            end
            #1;
            if (chk_on) begin
                check("model_digits",   sw.digits,            to_digits(m_cnt));
                check("model_running",  {15'd0, sw.running},  {15'd0, m_mode == M_RUN});
                check("model_rollover", {15'd0, sw.rollover}, {15'd0, m_roll});
            end
        end
    end

    // Called at a falling edge; applies inputs for the next rising edge, returns at the following falling edge.
    task automatic cyc(input logic t, input logic s, input logic c);
        sw.tick_in    = t;
        sw.start_stop = s;
        sw.clear      = c;
        @(negedge clock_in);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic start_ev();
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic lit(input string name, input logic [15:0] d, input logic r, input logic ro);
        check({name, "_digits"},   sw.digits,            d);
        check({name, "_running"},  {15'd0, sw.running},  {15'd0, r});
        check({name, "_rollover"}, {15'd0, sw.rollover}, {15'd0, ro});
    endtask

    logic ss_rand;

    initial begin
        sw.tick_in    = 1'b0;
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        @(negedge clock_in);

        // Test 1: start then ten ticks
        do_reset();
        lit("reset", 16'h0000, 1'b0, 1'b0);
        start_ev();
        tick(10);
        lit("t1", 16'h0010, 1'b1, 1'b0);

        // Test 2: advance to 59:58, then wrap
        tick(3588);
        lit("t2_pre", 16'h5958, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        lit("t2_max", 16'h5959, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        lit("t2_wrap", 16'h0000, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        lit("t2_after", 16'h0000, 1'b1, 1'b0);

        // Test 3: pause with a coincident tick from RUNNING
        do_reset();
        start_ev();
        tick(5);
        lit("t3_pre", 16'h0005, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        lit("t3_pause", 16'h0006, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        tick(3);
        lit("t3_hold", 16'h0006, 1'b0, 1'b0);

        // Test 4: resume with a coincident tick from PAUSED
        cyc(1'b1, 1'b1, 1'b0);
        lit("t4_resume", 16'h0006, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        tick(1);
        lit("t4_next", 16'h0007, 1'b1, 1'b0);

        // Test 5: clear at 12:34 with start_stop held through clear release
        tick(747);
        lit("t5_pre", 16'h1234, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        lit("t5_clear", 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        repeat (5) begin
            cyc(1'b1, 1'b1, 1'b0);
            cyc(1'b0, 1'b1, 1'b0);
        end
        lit("t5_hold", 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        start_ev();
        lit("t5_restart", 16'h0000, 1'b1, 1'b0);
        tick(1);
        lit("t5_count", 16'h0001, 1'b1, 1'b0);

        // Test 6: long-held tick_in is one increment; reset at 03:07
        do_reset();
        start_ev();
        repeat (1000) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        lit("t6_held", 16'h0001, 1'b1, 1'b0);
        tick(186);
        lit("t6_pre", 16'h0307, 1'b1, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        lit("t6_reset", 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;

        // Randomized phase against the model
        ss_rand = 1'b0;
        repeat (4000) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) ss_rand = ~ss_rand;
            cyc(1'($urandom_range(0, 1)), ss_rand, ($urandom_range(0, 99) < 2));
        end
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 The block SHALL have parameter SEC_TENS_MAX, default 5, meaning the highest seconds-tens digit value.
REQ-002 The block SHALL have parameter MIN_TENS_MAX, default 5, meaning the highest minutes-tens digit value.
REQ-003 The block SHALL have port clock_in, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port tick_in, input, 1 bit: the divided square wave from the upstream clock divider, synchronous to clock_in, used only as data.
REQ-006 The block SHALL have port start_stop, input, 1 bit: a level control whose rising edge toggles run/pause.
REQ-007 The block SHALL have port clear, input, 1 bit: a level control; while high, the block holds zero and IDLE.
REQ-008 The block SHALL have port digits, output, 16 bits: BCD {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
REQ-009 The block SHALL have port running, output, 1 bit: high while state is RUNNING.
REQ-010 The block SHALL have port rollover, output, 1 bit: a one-cycle pulse on wrap from max to 00:00.

Function
REQ-011 The block SHALL detect a tick as tick_in==1 while the registered tick_prev==0; tick_prev SHALL update every cycle.
REQ-012 The block SHALL detect a start event as start_stop==1 while the registered ss_prev==0; ss_prev SHALL update every cycle.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUNNING and PAUSED.
REQ-014 Start events SHALL drive these transitions: IDLE->RUNNING, RUNNING->PAUSED, PAUSED->RUNNING. With no start event, the state SHALL hold.
REQ-015 A tick SHALL increment the count only if the current-cycle state is RUNNING, with the new value visible on digits the following cycle (latency 1 clock from the tick sample).
REQ-016 A tick and a start event in the same cycle SHALL be resolved on the pre-transition state.
  - From RUNNING: the tick is counted and the state goes to PAUSED.
  - From PAUSED or IDLE: the tick is ignored.
REQ-017 Increment rules:
  - sec_ones counts 0..9 and carries.
  - sec_tens counts 0..SEC_TENS_MAX and carries.
  - min_ones counts 0..9 and carries.
  - min_tens counts 0..MIN_TENS_MAX.
REQ-018 An increment at the maximum value (59:59 by default) SHALL wrap digits to 0000 and assert rollover for exactly one cycle; the state SHALL remain RUNNING.
REQ-019 clear SHALL take priority over ticks and start events.
  - While clear is high: digits=0, state=IDLE, rollover=0.
  - tick_prev and ss_prev still update, so a start_stop held high through clear does not generate a start event when clear falls.
REQ-020 No digit SHALL ever hold a value outside its legal BCD range.
REQ-021 running SHALL be a registered decode of state; digits and rollover SHALL be registered outputs.

Reset
REQ-022 On reset the block SHALL set: digits=16'h0000, running=0, rollover=0, state=IDLE, tick_prev=0, ss_prev=0.
REQ-023 Reset asserted mid-count SHALL abandon the count in the next cycle with no rollover pulse.
REQ-024 Reset SHALL take priority over clear and all other inputs.

Structure
REQ-025 A shared package SHALL hold:
  - the FSM state encoding (IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2);
  - BCD digit width 4;
  - the ones-digit maximum 9.
REQ-026 Each digit SHALL be an instance of one sub-module, bcd_digit, with:
  - inputs clock_in, reset, clear, inc, and max value;
  - outputs value and carry.
REQ-027 carry SHALL be combinational, (inc && value==max); the next digit's inc SHALL be the previous digit's carry.
REQ-028 rollover SHALL be registered from min_tens carry.

Verification
REQ-029 Directed test 1: reset, start event, 10 ticks -> running=1, digits=16'h0010.
REQ-030 Directed test 2: preload to 59:58 by ticking, then 2 ticks -> digits=16'h0000 one cycle after the 2nd tick, rollover high for exactly one cycle, running stays 1.
REQ-031 Directed test 3: RUNNING at 00:05, start event and tick in the same cycle -> digits=16'h0006, running=0; 3 further ticks -> digits stay 16'h0006.
REQ-032 Directed test 4: PAUSED at 00:06, start event and tick in the same cycle -> running=1, digits=16'h0006; the next tick gives 16'h0007.
REQ-033 Directed test 5: RUNNING at 12:34, clear pulsed high with a simultaneous tick, then start_stop held high through the clear falling edge -> digits=16'h0000 and running=0, and both hold until a new start_stop rising edge.
REQ-034 Directed test 6: tick_in held high for 1000 cycles -> exactly one increment; reset asserted at 03:07 -> all outputs zero the next cycle.
